// File: rtl/module_hamming_tx.sv
// SECDED(8,4) transmit end: encodes a 4-bit word, XORs in an error-injection mask,
// and sends the codeword LSB first as an 8N1 UART frame (start, 8 data, stop).
module module_hamming_tx #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] data_i,
   input  logic [7:0] err_mask_i,
   input  logic       valid_i,
   output logic       ready_o,
   output logic       tx_o,
   output logic       busy_o,
   output logic       done_o,
   output logic [7:0] codeword_o,
   output logic [7:0] frame_cnt_o
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      bit_q, bit_d;
   logic            tx_q, tx_d;
   logic            done_q, done_d;
   logic [7:0]      cw_q, cw_d;
   logic [7:0]      frame_q, frame_d;
   logic            last;
   logic [2:0]      bit_nxt;

   // Codeword bit i is Hamming position i; bit 0 carries the overall parity.
   function automatic logic [7:0] encode(input logic [3:0] d);
      logic [7:0] c;
      c    = '0;
      c[3] = d[0];
      c[5] = d[1];
      c[6] = d[2];
      c[7] = d[3];
      c[1] = d[0] ^ d[1] ^ d[3];
      c[2] = d[0] ^ d[2] ^ d[3];
      c[4] = d[1] ^ d[2] ^ d[3];
      c[0] = ^c[7:1];
      return c;
   endfunction

   assign last    = (cnt_q == LAST);
   assign bit_nxt = bit_q + 3'd1;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      tx_d    = tx_q;
      done_d  = 1'b0;
      cw_d    = cw_q;
      frame_d = frame_q;
      case (state_q)
         S_IDLE: begin
            tx_d = 1'b1;
            if (valid_i) begin
               state_d = S_START;
               cnt_d   = '0;
               tx_d    = 1'b0;
               cw_d    = encode(data_i) ^ err_mask_i;
            end
         end
         S_START: begin
            if (last) begin
               state_d = S_DATA;
               cnt_d   = '0;
               bit_d   = 3'd0;
               tx_d    = cw_q[0];
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DATA: begin
            if (last) begin
               cnt_d = '0;
               if (bit_q == 3'd7) begin
                  state_d = S_STOP;
                  tx_d    = 1'b1;
               end else begin
                  bit_d = bit_nxt;
                  tx_d  = cw_q[bit_nxt];
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_STOP: begin
            if (last) begin
               // Count lands together with the done pulse in the first idle cycle.
               state_d = S_IDLE;
               cnt_d   = '0;
               done_d  = 1'b1;
               frame_d = frame_q + 8'd1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         tx_q    <= 1'b1;
         done_q  <= 1'b0;
         cw_q    <= '0;
         frame_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         tx_q    <= tx_d;
         done_q  <= done_d;
         cw_q    <= cw_d;
         frame_q <= frame_d;
      end
   end

   assign busy_o      = (state_q != S_IDLE);
   assign ready_o     = (state_q == S_IDLE);
   assign tx_o        = tx_q;
   assign done_o      = done_q;
   assign codeword_o  = cw_q;
   assign frame_cnt_o = frame_q;

endmodule

// File: tb/tb_module_hamming_tx.sv
// Bench for module_hamming_tx: a frame-position model of two instances
// (4 and 1 clocks per bit) checked every cycle, plus directed literal checks.
module tb_module_hamming_tx;

   logic       clk;
   logic       rst_n;
   logic       vin  [2];
   logic [3:0] din  [2];
   logic [7:0] min  [2];
   logic       rdy_w[2];
   logic       tx_w [2];
   logic       bsy_w[2];
   logic       dn_w [2];
   logic [7:0] cw_w [2];
   logic [7:0] fc_w [2];

   int checks   = 0;
   int failures = 0;
   bit cmp_en   = 0;

   module_hamming_tx #(.CLKS_PER_BIT(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .data_i(din[0]), .err_mask_i(min[0]), .valid_i(vin[0]),
      .ready_o(rdy_w[0]), .tx_o(tx_w[0]), .busy_o(bsy_w[0]), .done_o(dn_w[0]),
      .codeword_o(cw_w[0]), .frame_cnt_o(fc_w[0]));

   module_hamming_tx #(.CLKS_PER_BIT(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .data_i(din[1]), .err_mask_i(min[1]), .valid_i(vin[1]),
      .ready_o(rdy_w[1]), .tx_o(tx_w[1]), .busy_o(bsy_w[1]), .done_o(dn_w[1]),
      .codeword_o(cw_w[1]), .frame_cnt_o(fc_w[1]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int nb(input int u);
      return (u == 0) ? 4 : 1;
   endfunction

   // Data bits go to positions 3,5,6,7; parity p covers every position whose index has bit p set.
   function automatic logic [7:0] model_enc(input logic [3:0] d);
      logic [7:0] c;
      int dpos[4];
      c = '0;
      dpos = '{3, 5, 6, 7};
      for (int k = 0; k < 4; k++) c[dpos[k]] = d[k];
      for (int p = 1; p <= 4; p = p * 2)
         for (int j = 1; j <= 7; j++)
            if (j != p && (j & p) != 0) c[p] = c[p] ^ c[j];
      c[0] = ^c[7:1];
      return c;
   endfunction

   // Receiver model: {double, single, syndrome[2:0], corrected data[3:0]}.
   function automatic logic [8:0] rx(input logic [7:0] c);
      int s;
      logic par, sgl, dbl;
      logic [7:0] f;
      s = 0;
      for (int j = 1; j <= 7; j++) if (c[j]) s = s ^ j;
      par = ^c;
      f = c;
      sgl = par;
      dbl = !par && (s != 0);
      if (par && s != 0) f[s] = ~f[s];
      return {dbl, sgl, s[2:0], f[7], f[6], f[5], f[3]};
   endfunction

   int         pos_m [2];
   logic [7:0] cw_m  [2];
   logic [7:0] cnt_m [2];
   logic       done_m[2];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int u = 0; u < 2; u++) begin
            pos_m[u]  <= -1;
            cw_m[u]   <= '0;
            cnt_m[u]  <= '0;
            done_m[u] <= 1'b0;
         end
      end else begin
         for (int u = 0; u < 2; u++) begin
            done_m[u] <= 1'b0;
            if (pos_m[u] >= 0) begin
               if (pos_m[u] + 1 == 10 * nb(u)) begin
                  pos_m[u]  <= -1;
                  done_m[u] <= 1'b1;
                  cnt_m[u]  <= cnt_m[u] + 8'd1;
               end else begin
                  pos_m[u] <= pos_m[u] + 1;
               end
            end else if (vin[u]) begin
               pos_m[u] <= 0;
               cw_m[u]  <= model_enc(din[u]) ^ min[u];
            end
         end
      end
   end

   function automatic logic exp_tx(input int u);
      int slot;
      if (pos_m[u] < 0) return 1'b1;
      slot = pos_m[u] / nb(u);
      if (slot == 0) return 1'b0;
      if (slot <= 8) return cw_m[u][slot-1];
      return 1'b1;
   endfunction

   always @(negedge clk) begin
      if (cmp_en) begin
         for (int u = 0; u < 2; u++) begin
            chk($sformatf("u%0d_tx", u),    int'(tx_w[u]),  int'(exp_tx(u)));
            chk($sformatf("u%0d_busy", u),  int'(bsy_w[u]), int'(pos_m[u] >= 0));
            chk($sformatf("u%0d_ready", u), int'(rdy_w[u]), int'(pos_m[u] < 0));
            chk($sformatf("u%0d_done", u),  int'(dn_w[u]),  int'(done_m[u]));
            chk($sformatf("u%0d_cw", u),    int'(cw_w[u]),  int'(cw_m[u]));
            chk($sformatf("u%0d_fcnt", u),  int'(fc_w[u]),  int'(cnt_m[u]));
         end
      end
   end

   task automatic send0(input logic [3:0] d, input logic [7:0] m);
      @(negedge clk);
      vin[0] = 1'b1; din[0] = d; min[0] = m;
      @(negedge clk);
      vin[0] = 1'b0;
   endtask

   task automatic frame_check(input string name, input logic [3:0] d, input logic [7:0] m,
                              input int exp_cw, input int exp_rx);
      send0(d, m);
      repeat (41) @(negedge clk);
      chk({name, "_cw"}, int'(cw_w[0]), exp_cw);
      chk({name, "_rx"}, int'(rx(cw_w[0])), exp_rx);
   endtask

   initial begin
      int seq_err, first_bad, ndone, dcyc[3];
      logic [7:0] pat;
      logic exp;
      rst_n = 1'b0;
      for (int u = 0; u < 2; u++) begin
         vin[u] = 1'b0; din[u] = '0; min[u] = '0;
      end
      #12;
      chk("rst_tx", int'(tx_w[0]), 1);
      chk("rst_ready", int'(rdy_w[0]), 1);
      chk("rst_busy", int'(bsy_w[0]), 0);
      chk("rst_cw", int'(cw_w[0]), 0);
      chk("rst_fcnt", int'(fc_w[0]), 0);
      #10 rst_n = 1'b1;
      cmp_en = 1'b1;

      // Test 1: 4'hB -> 8'hAA, exact serial waveform
      send0(4'hB, 8'h00);
      pat = 8'hAA;
      seq_err = 0; first_bad = -1;
      for (int i = 0; i < 40; i++) begin
         exp = (i < 4) ? 1'b0 : (i < 36) ? pat[(i-4)/4] : 1'b1;
         if (tx_w[0] !== exp || dn_w[0] !== 1'b0) begin
            seq_err++;
            if (first_bad < 0) first_bad = i;
         end
         @(negedge clk);
      end
      chk("t1_seq_errors", seq_err, 0);
      if (seq_err != 0) $display("  first bad cycle %0d", first_bad);
      chk("t1_done", int'(dn_w[0]), 1);
      chk("t1_fcnt", int'(fc_w[0]), 1);
      chk("t1_cw", int'(cw_w[0]), 'hAA);
      chk("t1_ready", int'(rdy_w[0]), 1);

      // Tests 2 and 3: clean, single and double error codewords
      frame_check("t2_0", 4'h0, 8'h00, 'h00, 9'b0_0_000_0000);
      frame_check("t2_F", 4'hF, 8'h00, 'hFF, 9'b0_0_000_1111);
      frame_check("t3_sec", 4'hB, 8'h10, 'hBA, 9'b0_1_100_1011);
      frame_check("t3_ded", 4'hB, 8'h06, 'hAC, {2'b10, 3'b011, 4'b1011});
      chk("t3_fcnt", int'(fc_w[0]), 5);

      // Test 4: valid held for three back-to-back frames, data changed mid-frame
      @(negedge clk);
      vin[0] = 1'b1; din[0] = 4'h5; min[0] = 8'h00;
      ndone = 0;
      for (int c = 0; c < 140; c++) begin
         @(negedge clk);
         if (c == 10) din[0] = 4'h3;
         if (c == 82) vin[0] = 1'b0;
         if (c == 90) din[0] = 4'hF;
         if (dn_w[0]) begin
            if (ndone < 3) dcyc[ndone] = c;
            ndone++;
         end
      end
      chk("t4_ndone", ndone, 3);
      chk("t4_first_done", dcyc[0], 40);
      chk("t4_gap1", dcyc[1] - dcyc[0], 41);
      chk("t4_gap2", dcyc[2] - dcyc[1], 41);
      chk("t4_fcnt", int'(fc_w[0]), 8);
      chk("t4_cw", int'(cw_w[0]), 'h3C);

      // Test 5: asynchronous reset in the middle of a frame
      send0(4'h0, 8'h00);
      repeat (17) @(negedge clk);
      chk("t5_tx_before", int'(tx_w[0]), 0);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_tx", int'(tx_w[0]), 1);
      chk("t5_ready", int'(rdy_w[0]), 1);
      chk("t5_busy", int'(bsy_w[0]), 0);
      chk("t5_fcnt", int'(fc_w[0]), 0);
      @(negedge clk);
      rst_n = 1'b1;
      frame_check("t5_next", 4'hB, 8'h00, 'hAA, 9'b0_0_000_1011);
      chk("t5_fcnt_after", int'(fc_w[0]), 1);

      // Test 6: one clock per bit, 256 back-to-back frames wrap the counter
      @(negedge clk);
      vin[1] = 1'b1; din[1] = 4'h6; min[1] = 8'h00;
      ndone = 0;
      for (int c = 0; c < 2830; c++) begin
         @(negedge clk);
         if (c == 2805) vin[1] = 1'b0;
         if (dn_w[1]) ndone++;
         if (c == 10) chk("t6_first_done", int'(dn_w[1]), 1);
         if (c == 2804) chk("t6_fcnt_255", int'(fc_w[1]), 255);
      end
      chk("t6_ndone", ndone, 256);
      chk("t6_fcnt_wrap", int'(fc_w[1]), 0);
      chk("t6_ready", int'(rdy_w[1]), 1);

      cmp_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
